snd_fifo: RTL
=============

SND_FIFO -- requirements
Module: snd_fifo

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, number of 16-bit words held; SHALL be a power of two, 2..16.
REQ-002 Parameter: DIV_BASE, 640, clk32 cycles per sample at the fastest rate (32 MHz / 640 = 50 kHz).
REQ-003 Port: clk32  in  1  the only clock; all state SHALL update on its rising edge.
REQ-004 Port: porb  in  1  reset, synchronous, active-low.
REQ-005 Port: sndon  in  1  sound DMA enable; low SHALL flush the block.
REQ-006 Port: sload_n  in  1  active-low word-load strobe from the MCU; a load SHALL be one high-to-low transition seen at clk32.
REQ-007 Port: din  in  16  DMA data word; SHALL be captured in the cycle the falling edge of sload_n is detected.
REQ-008 Port: rate  in  2  sample rate select: 0=DIV_BASE*8, 1=*4, 2=*2, 3=*1 clk32 cycles per sample.
REQ-009 Port: mono  in  1  1 = mono (one byte per sample), 0 = stereo (one word per sample).
REQ-010 Port: sreq  out  1  sound DMA request to the MCU.
REQ-011 Port: left, right  out  8 each  signed sample outputs.
REQ-012 Port: underrun, overflow  out  1 each  sticky error flags.

Function
REQ-013 Load detect SHALL register sload_n; a load SHALL occur when registered value is 1 and current is 0; a held-low sload_n SHALL give exactly one load.
REQ-014 FIFO SHALL have a write pointer, a read pointer and a count of width log2(FIFO_DEPTH)+1; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-015 sreq SHALL equal sndon AND (count <= FIFO_DEPTH/2), registered, so it changes one clk32 cycle after the count changes.
REQ-016 A load while count == FIFO_DEPTH SHALL drop the word, leave the FIFO unchanged and set overflow.
REQ-017 The rate divider SHALL count down from the selected period minus 1 and emit a one-cycle tick at 0; a change of rate SHALL take effect at the next reload.
REQ-018 Stereo tick with count > 0: SHALL pop one word, left <= din[15:8], right <= din[7:0], both updated on the cycle after the tick.
REQ-019 Mono tick: SHALL output high byte to both channels, then on the next tick the low byte to both; the word SHALL be popped on the low-byte tick; a byte-phase flag SHALL track this.
REQ-020 Tick with count == 0: left/right SHALL hold, underrun SHALL be set, byte phase SHALL not advance.
REQ-021 Load and pop in the same cycle SHALL leave count unchanged; when count == FIFO_DEPTH, simultaneous load and pop SHALL accept the load (pop first).
REQ-022 sndon low SHALL, at the next edge: clear pointers, count, byte phase and divider; force left/right to 0 and sreq to 0; ignore loads; flags SHALL hold.
REQ-023 Rising edge of sndon SHALL clear underrun and overflow; first tick SHALL occur a full period later.

Reset
REQ-024 porb low SHALL set: count, pointers, divider, byte phase 0; left, right 0; sreq 0; underrun, overflow 0; registered sload_n 1.
REQ-025 Reset mid-operation SHALL discard FIFO contents; no load or tick SHALL be acted on in the reset cycle.

Configuration
REQ-026 Macro SND_FIFO_MONO_EN: when defined, mono input and byte-phase logic per REQ-019 SHALL exist; when undefined, mono SHALL be ignored and behaviour SHALL be stereo only.

Structure
REQ-027 Shared package snd_pkg SHALL hold the rate enum (RATE_6K, RATE_12K, RATE_25K, RATE_50K) and the DIV_BASE default constant.
REQ-028 The divider SHALL be a sub-module snd_rate_div (clk32, porb, clear, rate -> tick); FIFO storage SHALL stay inline.

Verification
REQ-029 Reset, sndon=1, no loads -> sreq=1 two cycles later; left=right=0; first tick at rate 3 after 640 cycles sets underrun.
REQ-030 Stereo, rate 3, load 0x7F80 -> at the next tick left=0x7F, right=0x80; count returns to 0.
REQ-031 Load 5 words with FIFO_DEPTH=4 and no tick -> overflow=1, sreq=0 after the 3rd load, first 4 words emitted in order.
REQ-032 Mono (SND_FIFO_MONO_EN), load 0x1234 -> tick1 left=right=0x12, tick2 left=right=0x34, pop on tick2.
REQ-033 Full FIFO, load coincident with tick -> word accepted, overflow stays 0, count stays 4.
REQ-034 sndon dropped with 3 words queued -> next cycle count=0, sreq=0, outputs 0; sload_n pulses ignored.

Source files
------------

// File: rtl/snd_pkg.sv
// Shared sound-path types: sample-rate select and divider base period.
// Rate code n selects DIV_BASE << (3 - n) clk32 cycles per sample.
package snd_pkg;

    localparam int unsigned DIV_BASE_DEF = 640;

    typedef enum logic [1:0] {
        RATE_6K  = 2'd0,
        RATE_12K = 2'd1,
        RATE_25K = 2'd2,
        RATE_50K = 2'd3
    } rate_e;

    function automatic int unsigned rate_period(rate_e r, int unsigned base);
        int unsigned p;
        p = base;
        unique case (r)
            RATE_6K:  p = base * 8;
            RATE_12K: p = base * 4;
            RATE_25K: p = base * 2;
            RATE_50K: p = base;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/snd_fifo_if.sv
// MCU-to-sound bus: DMA load strobe/data, rate/mode controls, samples and flags.
// master = MCU/bench side, slave = snd_fifo.
interface snd_fifo_if;
    logic        sndon;
    logic        sload_n;
    logic [15:0] din;
    logic [1:0]  rate;
    logic        mono;
    logic        sreq;
    logic [7:0]  left;
    logic [7:0]  right;
    logic        underrun;
    logic        overflow;

    modport master (
        output sndon, sload_n, din, rate, mono,
        input  sreq, left, right, underrun, overflow
    );

    modport slave (
        input  sndon, sload_n, din, rate, mono,
        output sreq, left, right, underrun, overflow
    );
endinterface

// File: rtl/snd_rate_div.sv
// Sample-rate divider: reloads period-1 from the current rate, ticks at zero.
// First cycle after clear only arms the counter, so the first tick is a full period out.
module snd_rate_div
    import snd_pkg::*;
#(
    parameter int unsigned DIV_BASE = DIV_BASE_DEF
) (
    input  logic  clk32,
    input  logic  porb,
    input  logic  clear,
    input  rate_e rate,
    output logic  tick
);

    localparam int CW = $clog2(DIV_BASE * 8);

    logic [CW-1:0] r_cnt;
    logic          r_run;
    logic [CW-1:0] w_reload;

    assign w_reload = CW'(rate_period(rate, DIV_BASE) - 1);
    assign tick     = r_run && (r_cnt == '0);

    always_ff @(posedge clk32) begin
        if (!porb || clear) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (!r_run || tick) begin
            r_cnt <= w_reload;
            r_run <= 1'b1;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/snd_fifo.sv
// Sound DMA FIFO: edge-detected word loads, rate-paced sample output, sticky flags.
// Define SND_FIFO_MONO_EN to enable mono (one byte per sample) playback.
module snd_fifo
    import snd_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter int unsigned DIV_BASE   = DIV_BASE_DEF
) (
    input logic       clk32,
    input logic       porb,
    snd_fifo_if.slave bus
);

    localparam int           AW   = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]  FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]  HALF = (AW + 1)'(FIFO_DEPTH / 2);

    logic [15:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          r_sload_q;
    logic          r_sndon_q;
    logic          r_sreq;
    logic          r_under;
    logic          r_over;
    logic [7:0]    r_left;
    logic [7:0]    r_right;

    logic          w_tick;
    logic          w_load;
    logic          w_rise;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_emit;
    logic [15:0]   w_head;
    logic [7:0]    w_l;
    logic [7:0]    w_r;

`ifdef SND_FIFO_MONO_EN
    logic          r_phase;
`endif

    snd_rate_div #(
        .DIV_BASE (DIV_BASE)
    ) u_div (
        .clk32 (clk32),
        .porb  (porb),
        .clear (~bus.sndon),
        .rate  (rate_e'(bus.rate)),
        .tick  (w_tick)
    );

    assign w_load  = bus.sndon & r_sload_q & ~bus.sload_n;
    assign w_rise  = bus.sndon & ~r_sndon_q;
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL);
    assign w_head  = r_mem[r_rd];
    assign w_emit  = w_tick & ~w_empty;

`ifdef SND_FIFO_MONO_EN
    // mono holds the word until its low byte has played
    assign w_pop = w_emit & (r_phase | ~bus.mono);
`else
    assign w_pop = w_emit;
`endif

    // popping first makes room, so a full FIFO still takes a coincident load
    assign w_push = w_load & (~w_full | w_pop);

    always_comb begin
        w_l = w_head[15:8];
        w_r = w_head[7:0];
`ifdef SND_FIFO_MONO_EN
        if (bus.mono) begin
            if (r_phase) begin
                w_l = w_head[7:0];
                w_r = w_head[7:0];
            end else begin
                w_l = w_head[15:8];
                w_r = w_head[15:8];
            end
        end
`endif
    end

    always_ff @(posedge clk32) begin
        if (porb && w_push) begin
            r_mem[r_wr] <= bus.din;
        end
    end

    always_ff @(posedge clk32) begin
        if (!porb) begin
            r_wr      <= '0;
            r_rd      <= '0;
            r_count   <= '0;
            r_sload_q <= 1'b1;
            r_sndon_q <= 1'b0;
            r_sreq    <= 1'b0;
            r_under   <= 1'b0;
            r_over    <= 1'b0;
            r_left    <= '0;
            r_right   <= '0;
        end else begin
            r_sload_q <= bus.sload_n;
            r_sndon_q <= bus.sndon;
            if (!bus.sndon) begin
                r_wr    <= '0;
                r_rd    <= '0;
                r_count <= '0;
                r_sreq  <= 1'b0;
                r_left  <= '0;
                r_right <= '0;
            end else begin
                if (w_push) begin
                    r_wr <= r_wr + 1'b1;
                end
                if (w_pop) begin
                    r_rd <= r_rd + 1'b1;
                end
                unique case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
                if (w_emit) begin
                    r_left  <= w_l;
                    r_right <= w_r;
                end
                r_sreq <= (r_count <= HALF);
            end
            if (w_rise) begin
                r_under <= 1'b0;
                r_over  <= 1'b0;
            end else begin
                if (w_tick && w_empty) begin
                    r_under <= 1'b1;
                end
                if (w_load && w_full && !w_pop) begin
                    r_over <= 1'b1;
                end
            end
        end
    end

`ifdef SND_FIFO_MONO_EN
    always_ff @(posedge clk32) begin
        if (!porb || !bus.sndon) begin
            r_phase <= 1'b0;
        end else if (w_emit) begin
            r_phase <= bus.mono & ~r_phase;
        end
    end
`endif

    assign bus.sreq     = r_sreq;
    assign bus.left     = r_left;
    assign bus.right    = r_right;
    assign bus.underrun = r_under;
    assign bus.overflow = r_over;

endmodule
